uart_tx_queue: RTL and testbench

//  Word FIFO and send sequencer in front of the UART transmitter. The CPU side pushes 16-bit words

---
 rtl/uart_tx_queue_pkg.sv | 18 +
 rtl/uart_tx_queue_sync_fifo16.sv | 58 +++++
 rtl/uart_tx_queue.sv | 140 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared types and defaults for the UART transmit word queue.
// Optional watchdog is enabled by defining UART_TXQ_TIMEOUT_EN.
package uart_tx_queue_pkg;

    localparam int TXQ_DEPTH          = 8;
    localparam int TXQ_ADDR_W         = 3;
    localparam int TXQ_TIMEOUT_CYCLES = 5000;
    localparam int TXQ_TIMEOUT_W      = 13;
    localparam int TXQ_DATA_W         = 16;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_CLR  = 2'd2,
        S_WAIT_DONE = 2'd3
    } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_sync_fifo16.sv
// 16-bit synchronous word FIFO: storage, pointers and occupancy count.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo16
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEPTH,
    parameter int ADDR_W = TXQ_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [TXQ_DATA_W-1:0] push_data,
    input  logic                  pop,
    output logic [TXQ_DATA_W-1:0] head,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  empty
);

    logic [TXQ_DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Word FIFO plus send sequencer feeding the UART transmitter.
// Define UART_TXQ_TIMEOUT_EN to add the done watchdog and timeout_err.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH          = TXQ_DEPTH,
    parameter int ADDR_W         = TXQ_ADDR_W
`ifdef UART_TXQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TXQ_TIMEOUT_CYCLES,
    parameter int TIMEOUT_W      = TXQ_TIMEOUT_W
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    input  logic [TXQ_DATA_W-1:0] push_data,
    output logic                  push_ready,
    input  logic                  uart_hold,
    input  logic                  uart_done,
    output logic                  uart_in_and_send,
    output logic [TXQ_DATA_W-1:0] uart_data,
    output logic                  uart_data_oe,
    output logic [ADDR_W:0]       count,
    output logic                  empty,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic                  timeout_err
);

    txq_state_t            state;
    logic                  full;
    logic                  pop;
    logic                  expire;
    logic [TXQ_DATA_W-1:0] head;

    sync_fifo16 #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign push_ready = !full;
    assign busy       = (state != S_IDLE);

    // The head stays queued until the UART reports done (or the watchdog fires).
    assign pop = ((state == S_WAIT_DONE) && uart_done) || expire;

`ifdef UART_TXQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 waiting;

    assign waiting = (state == S_WAIT_CLR) || (state == S_WAIT_DONE);
    assign expire  = waiting &&
                     (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end else if (clear_overflow) begin
                timeout_err <= 1'b0;
            end
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_valid && full) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            uart_in_and_send <= 1'b0;
            uart_data_oe     <= 1'b0;
            uart_data        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!empty && !uart_hold) begin
                        state            <= S_SEND;
                        uart_data        <= head;
                        uart_in_and_send <= 1'b1;
                        uart_data_oe     <= 1'b1;
                    end
                end
                S_SEND: begin
                    state            <= S_WAIT_CLR;
                    uart_in_and_send <= 1'b0;
                    uart_data_oe     <= 1'b0;
                end
                // A done level left over from the previous word must drop first.
                S_WAIT_CLR: begin
                    if (expire) begin
                        state <= S_IDLE;
                    end else if (!uart_done) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (expire || uart_done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a behavioural UART done model.
// Covers the UART_TXQ_TIMEOUT_EN watchdog when that macro is defined.
module tb_uart_tx_queue;

    localparam int TMO = 5000;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic [15:0] push_data;
    logic        push_ready;
    logic        uart_hold;
    logic        uart_done;
    logic        uart_in_and_send;
    logic [15:0] uart_data;
    logic        uart_data_oe;
    logic [3:0]  count;
    logic        empty;
    logic        busy;
    logic        overflow;
    logic        clear_overflow;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    bit          uart_auto = 1'b1;
    int          clr_dly   = 1;
    int          done_dly  = 3;

    uart_tx_queue dut (
        .clk              (clk),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_data        (push_data),
        .push_ready       (push_ready),
        .uart_hold        (uart_hold),
        .uart_done        (uart_done),
        .uart_in_and_send (uart_in_and_send),
        .uart_data        (uart_data),
        .uart_data_oe     (uart_data_oe),
        .count            (count),
        .empty            (empty),
        .busy             (busy),
        .overflow         (overflow),
        .clear_overflow   (clear_overflow),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] d, input bit acc);
        check("push_ready", 32'(push_ready), 32'(acc));
        push_valid = 1'b1;
        push_data  = d;
        if (acc) exp_q.push_back(d);
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && count == 0) break;
        end
        check({"drain_", tag}, {busy, 4'(count)}, 0);
        check({"sb_empty_", tag}, exp_q.size(), 0);
    endtask

    // UART model: checks the strobe against the scoreboard, then drops and
    // re-raises its done level after configurable delays.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_auto && uart_in_and_send) begin
                check("send_oe", 32'(uart_data_oe), 1);
                if (exp_q.size() == 0) check("unexpected_send", 1, 0);
                else check("send_data", 32'(uart_data), 32'(exp_q.pop_front()));
                @(negedge clk);
                check("strobe_1cyc", {uart_in_and_send, uart_data_oe}, 0);
                repeat (clr_dly - 1) @(negedge clk);
                uart_done = 1'b0;
                repeat (done_dly) @(negedge clk);
                uart_done = 1'b1;
            end
        end
    end

    initial begin
        reset          = 1'b1;
        push_valid     = 1'b0;
        push_data      = '0;
        uart_hold      = 1'b0;
        uart_done      = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_count", 32'(count), 0);
        check("rst_flags", {empty, busy, overflow, timeout_err}, 4'b1000);
        check("rst_uart", {uart_in_and_send, uart_data_oe, uart_data}, 0);
        check("rst_ready", 32'(push_ready), 1);

        // single word, latency and data
        push_word(16'hA55A, 1'b1);
        check("t1_count", 32'(count), 1);
        check("t1_no_strobe_yet", 32'(uart_in_and_send), 0);
        @(negedge clk);
        check("t1_strobe", 32'(uart_in_and_send), 1);
        check("t1_data", {uart_data_oe, uart_data}, {1'b1, 16'hA55A});
        wait_idle("t1", 100);
        check("t1_empty", 32'(empty), 1);

        // fill to full, overflow, in-order drain
        uart_hold = 1'b1;
        for (int i = 0; i < 8; i++) push_word(16'h1000 + 16'(i), 1'b1);
        check("t2_full_count", 32'(count), 8);
        push_word(16'hBAD0, 1'b0);
        check("t2_overflow", 32'(overflow), 1);
        check("t2_count_kept", 32'(count), 8);
        uart_hold = 1'b0;
        wait_idle("t2", 400);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("t2_ovf_clear", 32'(overflow), 0);

        // stale done level holds the FSM before waiting for done
        uart_done = 1'b1;
        clr_dly   = 6;
        push_word(16'h3C3C, 1'b1);
        @(negedge clk);
        check("t3_strobe", 32'(uart_in_and_send), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_no_early_pop", {busy, 4'(count)}, {1'b1, 4'd1});
        end
        wait_idle("t3", 100);
        clr_dly = 1;

        // hold blocks new sends
        uart_hold = 1'b1;
        push_word(16'h0101, 1'b1);
        push_word(16'h0202, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_held", {uart_in_and_send, busy}, 0);
        end
        uart_hold = 1'b0;
        @(negedge clk);
        check("t4_release_strobe", 32'(uart_in_and_send), 1);
        check("t4_count", 32'(count), 2);
        wait_idle("t4", 200);

        // push during the pop cycle of a full queue
        uart_auto = 1'b0;
        uart_done = 1'b0;
        uart_hold = 1'b1;
        for (int i = 0; i < 8; i++) push_word(16'h5000 + 16'(i), 1'b1);
        uart_hold = 1'b0;
        @(negedge clk);
        check("t5_strobe", 32'(uart_in_and_send), 1);
        check("t5_data", 32'(uart_data), 32'(exp_q.pop_front()));
        repeat (2) @(negedge clk);
        uart_done  = 1'b1;
        uart_hold  = 1'b1;
        check("t5_ready_full", 32'(push_ready), 0);
        push_valid = 1'b1;
        push_data  = 16'hDEAD;
        @(negedge clk);
        push_valid = 1'b0;
        check("t5_count", 32'(count), 7);
        check("t5_overflow", 32'(overflow), 1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        uart_auto = 1'b1;
        uart_hold = 1'b0;
        wait_idle("t5", 400);

        // reset while waiting for done
        uart_auto = 1'b0;
        uart_done = 1'b0;
        uart_hold = 1'b1;
        for (int i = 0; i < 3; i++) push_word(16'h7000 + 16'(i), 1'b1);
        uart_hold = 1'b0;
        @(negedge clk);
        check("t6_strobe", 32'(uart_in_and_send), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("t6_count", 32'(count), 0);
        check("t6_flags", {empty, busy, overflow, timeout_err}, 4'b1000);
        check("t6_uart", {uart_in_and_send, uart_data_oe, uart_data}, 0);
        uart_auto = 1'b1;

`ifdef UART_TXQ_TIMEOUT_EN
        // done never arrives: watchdog pops at exactly TMO clocks
        uart_auto = 1'b0;
        uart_done = 1'b0;
        push_word(16'h9999, 1'b1);
        exp_q.delete();
        @(negedge clk);
        check("t7_strobe", 32'(uart_in_and_send), 1);
        repeat (TMO - 1) @(negedge clk);
        check("t7_before", {timeout_err, 4'(count)}, {1'b0, 4'd1});
        @(negedge clk);
        check("t7_expire", {timeout_err, busy, 4'(count)}, {1'b1, 1'b0, 4'd0});
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("t7_tmo_clear", 32'(timeout_err), 0);
        uart_auto = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
